// File: rtl/instr_sequencer.sv
// Program sequencer: buffers a short program, then issues it (reps+1 times) over valid/ready.
// Optional SEQ_SKIP_ZERO_EN macro turns the SKIPZ word into a sequencer-only conditional skip.
module instr_sequencer #(
  parameter int DEPTH = 8,
  parameter int IW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     load_valid,
  input  logic [IW-1:0]            load_data,
  output logic                     load_ready,
  input  logic                     start,
  input  logic [3:0]               reps,
  input  logic                     abort,
  output logic                     issue_valid,
  output logic [IW-1:0]            issue_inst,
  input  logic                     issue_ready,
  input  logic [7:0]               res_data,
  input  logic                     res_zero,
  output logic [7:0]               last_result,
  output logic                     last_zero,
  output logic [$clog2(DEPTH)-1:0] pc,
  output logic                     busy,
  output logic                     done
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic [3:0]      reps_left_q, reps_left_d;
  logic [7:0]      last_result_q, last_result_d;
  logic            last_zero_q, last_zero_d;
  logic [IW-1:0]   prog_q [DEPTH];
  logic            wr_en_s;
  logic [IW-1:0]   cur_inst_s;
  logic            skip_s;
  logic            hs_s;
  logic [PW+1:0]   nxt_s;

  assign cur_inst_s = prog_q[pc_q];

`ifdef SEQ_SKIP_ZERO_EN
  function automatic logic is_skipz(input logic [IW-1:0] inst);
    return (inst[1:0] == 2'b00) && (inst[5:2] == 4'b1111);
  endfunction
  assign skip_s = (state_q == RUN) && is_skipz(cur_inst_s);
`else
  assign skip_s = 1'b0;
`endif

  assign issue_valid = (state_q == RUN) && !skip_s;
  assign issue_inst  = issue_valid ? cur_inst_s : {IW{1'b0}};
  assign load_ready  = (state_q == IDLE) && (count_q < DEPTH_C);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign pc          = pc_q;
  assign last_result = last_result_q;
  assign last_zero   = last_zero_q;
  assign hs_s        = issue_valid && issue_ready;

  // Next-state, buffer write enable and result capture.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    pc_d          = pc_q;
    reps_left_d   = reps_left_q;
    last_result_d = last_result_q;
    last_zero_d   = last_zero_q;
    wr_en_s       = 1'b0;
    nxt_s         = {2'b00, pc_q} + ((skip_s && last_zero_q) ? (PW+2)'(2) : (PW+2)'(1));
    case (state_q)
      IDLE: begin
        if (start && (count_q != {CW{1'b0}})) begin
          state_d     = RUN;
          pc_d        = {PW{1'b0}};
          reps_left_d = reps;
        end else if (clear) begin
          count_d = {CW{1'b0}};
        end else if (load_valid && (count_q < DEPTH_C)) begin
          wr_en_s = 1'b1;
          count_d = count_q + CW'(1);
        end else begin
          count_d = count_q;
        end
      end
      RUN: begin
        if (hs_s) begin
          last_result_d = res_data;
          last_zero_d   = res_zero;
        end else begin
          last_result_d = last_result_q;
        end
        // A skipped word advances without a handshake; abort freezes pc.
        if (abort) begin
          state_d = IDLE;
        end else if (hs_s || skip_s) begin
          if (nxt_s >= {1'b0, count_q}) begin
            if (reps_left_q == 4'd0) begin
              state_d = DONE;
            end else begin
              reps_left_d = reps_left_q - 4'd1;
              pc_d        = {PW{1'b0}};
            end
          end else begin
            pc_d = nxt_s[PW-1:0];
          end
        end else begin
          pc_d = pc_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= {CW{1'b0}};
      pc_q          <= {PW{1'b0}};
      reps_left_q   <= 4'd0;
      last_result_q <= 8'h00;
      last_zero_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      pc_q          <= pc_d;
      reps_left_q   <= reps_left_d;
      last_result_q <= last_result_d;
      last_zero_q   <= last_zero_d;
    end
  end

  // Program storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      prog_q[count_q[PW-1:0]] <= load_data;
    end
  end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

- Program sequencer for the 16-bit-instruction, 4-bit-register processor core.
- Stores a short program loaded one word at a time, then issues it in order to the core over a valid/ready handshake.
- Repeats the program a programmable number of times and captures each returned 8-bit result and zero flag.
- Sits between the host/pin interface and the core's instruction input, replacing direct pin-driven instruction entry.

## Interface

Parameters:
- DEPTH, 8: program buffer entries (power of two, 2..16)
- IW, 16: instruction width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  empty the program buffer; honoured in IDLE only
- load_valid  in  1  program word offered
- load_data  in  IW  program word
- load_ready  out  1  buffer accepts a word
- start  in  1  begin execution; honoured in IDLE only
- reps  in  4  extra passes; total passes = reps+1, sampled on start
- abort  in  1  stop execution
- issue_valid  out  1  instruction presented to core
- issue_inst  out  IW  instruction to core
- issue_ready  in  1  core accepts instruction
- res_data  in  8  core result, combinational, valid in the handshake cycle
- res_zero  in  1  core zero flag, valid in the handshake cycle
- last_result  out  8  result of the most recent accepted instruction
- last_zero  out  1  zero flag of the most recent accepted instruction
- pc  out  clog2(DEPTH)  current buffer index
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse

## Operation

- Storage: buffer of DEPTH×IW words (not reset); `count` holds 0..DEPTH entries.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - load_ready = (count < DEPTH).
  - load_valid && load_ready writes buf[count] and increments count.
  - clear sets count = 0 and has priority over a simultaneous load.
  - start with count != 0 sets pc = 0, latches reps into reps_left, and moves to RUN.
  - start with count == 0 is ignored.
  - start wins over a simultaneous load, which is dropped.
- RUN:
  - issue_valid = 1; issue_inst = buf[pc]. issue_inst = 0 whenever issue_valid = 0.
  - On handshake (issue_valid && issue_ready), res_data/res_zero are registered into last_result/last_zero.
  - End-of-pass, when pc reaches count-1:
    - reps_left == 0: move to DONE.
    - otherwise: decrement reps_left, set pc = 0, stay in RUN.
  - Otherwise pc increments.
  - Without a handshake, issue_inst is held stable and pc does not move.
  - abort moves to IDLE next cycle. If abort coincides with a handshake, the result is still captured. pc is left as is; count and buffer are preserved.
  - load, clear and start are ignored in RUN and DONE; load_ready = 0.
- DONE: done = 1 for exactly one cycle, then IDLE. abort in DONE has no extra effect.

## Timing

- Reset values:
  - state IDLE; issue_valid 0; issue_inst 0.
  - count 0; pc 0; reps_left 0.
  - last_result 0x00; last_zero 0.
  - busy 0; done 0; load_ready 1.
- All outputs are decoded from registers only; there is no combinational path from any input to any output.
- Latency and throughput:
  - start sampled at edge N: issue_valid first high after edge N, i.e. in cycle N+1.
  - Peak rate is one instruction per cycle with issue_ready held high.
  - A pass of count instructions with no stalls takes count cycles.
  - Total run time is (reps+1)·count + 1 cycles, including the DONE cycle.
- last_result updates on the edge that completes the handshake.
- rst mid-run returns all outputs to reset values immediately. Buffer contents are undefined for use because count resets to 0.

## Configuration

- Macro: SEQ_SKIP_ZERO_EN.
- Defined: SKIPZ becomes a sequencer-only instruction.
  - Encoding: inst[1:0] = 2'b00 and inst[5:2] = 4'b1111.
  - When buf[pc] is SKIPZ, issue_valid = 0 for that cycle and the word is never issued.
  - In one cycle, pc advances by 2 if last_zero = 1, else by 1.
  - An advance that reaches or passes count ends the pass under the normal end-of-pass rules.
  - last_result/last_zero are unchanged.
- Undefined: SKIPZ is issued to the core like any other word.

## Test plan

- Load three words 0x0000, 0x2463, 0x4460; start with reps=0 and issue_ready=1 -> three consecutive issues in buffer order, done pulses 4 cycles after start, last_result equals the res_data driven on the third handshake.
- Load DEPTH+1 words -> load_ready falls after the 8th accept, the 9th word is not stored, count = 8.
- Two words, reps=2, issue_ready toggled 1/0 each cycle -> 6 handshakes in order w0,w1,w0,w1,w0,w1, issue_inst stable through every stall, single done pulse.
- Abort in the same cycle as the 2nd handshake -> that result is captured, issue_valid = 0 next cycle, busy = 0, no done pulse, count unchanged; start again -> replays from pc = 0.
- Start with count = 0, and clear during RUN -> both ignored; clear plus load_valid in the same IDLE cycle -> count = 0.
- SEQ_SKIP_ZERO_EN: program [A, SKIPZ, B, C], core returns res_zero = 1 for A -> issued sequence A, C; with res_zero = 0 -> A, B, C.
